// File: rtl/chu_collision_probe_core.sv
// Collision probe: counts non-key pixels inside a window per frame; passes video through.
// Optional macro PROBE_OUTLINE_EN draws the window border on so_rgb.
module chu_collision_probe_core #(
    parameter int              CD          = 12,
    parameter logic [CD-1:0]   KEY_COLOR   = '0,
    parameter int              HMAX        = 640,
    parameter int              VMAX        = 480,
    parameter int              CW          = 19,
    parameter logic [CD-1:0]   OUTLINE_CLR = 12'hf00
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [10:0]   x,
    input  logic [10:0]   y,
    input  logic          cs,
    input  logic          write,
    input  logic          read,
    input  logic [13:0]   addr,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data,
    input  logic [CD-1:0] si_rgb,
    output logic [CD-1:0] so_rgb
);

    localparam logic [11:0]   HMAX_C  = 12'(HMAX);
    localparam logic [11:0]   VMAX_C  = 12'(VMAX);
    localparam logic [CW-1:0] ACC_MAX = '1;

    logic          enable_q;
    logic [10:0]   x0_q, y0_q, w_q, h_q;
    logic [10:0]   x_prev_q, y_prev_q;
    logic [CW-1:0] acc_q, acc_d;
    logic [CW-1:0] result_q, result_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   frame_q, frame_d;

    logic          wr_en, clr;
    logic          adv, frame_end, hit;
    logic [11:0]   x12, y12, x_end, y_end;
    logic          in_x, in_y, visible;

    assign wr_en = cs & write;
    assign clr   = wr_en & (addr[2:0] == 3'd5);

    // Window compares are done one bit wider so x0+w never wraps.
    assign x12   = {1'b0, x};
    assign y12   = {1'b0, y};
    assign x_end = {1'b0, x0_q} + {1'b0, w_q};
    assign y_end = {1'b0, y0_q} + {1'b0, h_q};
    assign in_x  = (x12 >= {1'b0, x0_q}) & (x12 < x_end);
    assign in_y  = (y12 >= {1'b0, y0_q}) & (y12 < y_end);

    assign visible   = (x12 < HMAX_C) & (y12 < VMAX_C);
    assign adv       = (x != x_prev_q) | (y != y_prev_q);
    assign frame_end = adv & (x == 11'd0) & (y == 11'd0);
    assign hit       = adv & enable_q & visible & in_x & in_y
                     & (si_rgb != KEY_COLOR);

    // CPU-programmed window and enable registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q <= 1'b0;
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
        end else if (wr_en) begin
            case (addr[2:0])
                3'd0:    enable_q <= wr_data[0];
                3'd1:    x0_q     <= wr_data[10:0];
                3'd2:    y0_q     <= wr_data[10:0];
                3'd3:    w_q      <= wr_data[10:0];
                3'd4:    h_q      <= wr_data[10:0];
                default: ;
            endcase
        end
    end

    // Previous coordinates, used to detect a pixel change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_prev_q <= '0;
            y_prev_q <= '0;
        end else begin
            x_prev_q <= x;
            y_prev_q <= y;
        end
    end

    // Accumulate hits; frame end latches the count and overrides a clear of done.
    always_comb begin
        acc_d    = acc_q;
        result_d = result_q;
        done_d   = done_q;
        ovf_d    = ovf_q;
        frame_d  = frame_q;
        if (clr) begin
            done_d = 1'b0;
            ovf_d  = 1'b0;
        end
        if (frame_end) begin
            result_d = acc_q;
            done_d   = 1'b1;
            frame_d  = frame_q + 16'd1;
            acc_d    = hit ? CW'(1) : '0;
        end else if (hit) begin
            if (acc_q == ACC_MAX) begin
                ovf_d = 1'b1;
            end else begin
                acc_d = acc_q + CW'(1);
            end
        end
    end

    // Counter and status state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            frame_q  <= '0;
        end else begin
            acc_q    <= acc_d;
            result_q <= result_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            frame_q  <= frame_d;
        end
    end

    // Register readback, purely combinational from the low address bits.
    always_comb begin
        rd_data = '0;
        case (addr[2:0])
            3'd0: rd_data = {30'b0, ovf_q, done_q};
            3'd1: rd_data = 32'(result_q);
            3'd2: rd_data = {16'b0, frame_q};
            3'd3: rd_data = {21'b0, x0_q};
            3'd4: rd_data = {21'b0, y0_q};
            3'd5: rd_data = {21'b0, w_q};
            3'd6: rd_data = {21'b0, h_q};
            3'd7: rd_data = {31'b0, enable_q};
            default: rd_data = '0;
        endcase
    end

`ifdef PROBE_OUTLINE_EN
    logic [11:0] x_last, y_last;
    logic        border;
    logic        unused_ok;

    assign x_last = x_end - 12'd1;
    assign y_last = y_end - 12'd1;
    assign border = enable_q & (w_q != 11'd0) & (h_q != 11'd0)
                  & ((((x12 == {1'b0, x0_q}) | (x12 == x_last)) & in_y)
                  | (((y12 == {1'b0, y0_q}) | (y12 == y_last)) & in_x));
    assign unused_ok = ^{read, addr[13:3], wr_data[31:11]};

    // Border pixels are replaced; counting above still sees si_rgb.
    always_comb begin
        so_rgb = border ? OUTLINE_CLR : si_rgb;
    end
`else
    logic unused_ok;

    assign unused_ok = ^{read, addr[13:3], wr_data[31:11], OUTLINE_CLR};

    // Plain pass-through of the video stream.
    always_comb begin
        so_rgb = si_rgb;
    end
`endif

endmodule

// File: tb/tb_chu_collision_probe_core.sv
// Randomized self-checking bench for chu_collision_probe_core.
// Two instances (CW=19 and CW=4) share stimulus; a per-pixel model predicts both.
`timescale 1ns/1ps
module tb_chu_collision_probe_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] x = '0, y = '0;
    logic        cs = 1'b0, write = 1'b0, read = 1'b0;
    logic [13:0] addr = '0;
    logic [31:0] wr_data = '0;
    logic [11:0] si_rgb = '0;
    logic [31:0] rd_data, rd4;
    logic [11:0] so_rgb, so4;

    int n_chk = 0;
    int n_fail = 0;

    // model state
    int m_en, m_x0, m_y0, m_w, m_h;
    int m_px, m_py, m_done, m_frame;
    int m_acc[2], m_res[2], m_ovf[2];
    int maxv[2] = '{524287, 15};

    chu_collision_probe_core dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .cs(cs), .write(write),
        .read(read), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .si_rgb(si_rgb), .so_rgb(so_rgb)
    );

    chu_collision_probe_core #(.CW(4)) dut4 (
        .clk(clk), .reset(reset), .x(x), .y(y), .cs(cs), .write(write),
        .read(read), .addr(addr), .wr_data(wr_data), .rd_data(rd4),
        .si_rgb(si_rgb), .so_rgb(so4)
    );

    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_en = 0; m_x0 = 0; m_y0 = 0; m_w = 0; m_h = 0;
        m_px = 0; m_py = 0; m_done = 0; m_frame = 0;
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = 0; m_res[k] = 0; m_ovf[k] = 0;
        end
    endfunction

    function automatic void model_clear();
        m_done = 0;
        for (int k = 0; k < 2; k++) m_ovf[k] = 0;
    endfunction

    function automatic void model_write(input int a, input int d);
        case (a)
            0: m_en = d & 1;
            1: m_x0 = d & 2047;
            2: m_y0 = d & 2047;
            3: m_w  = d & 2047;
            4: m_h  = d & 2047;
            5: model_clear();
            default: ;
        endcase
    endfunction

    function automatic void model_pixel(input int px, input int py, input int rgb);
        bit hit;
        if (px == m_px && py == m_py) return;
        hit = m_en != 0 && px < 640 && py < 480 &&
              px >= m_x0 && px < m_x0 + m_w &&
              py >= m_y0 && py < m_y0 + m_h && rgb != 0;
        if (px == 0 && py == 0) begin
            for (int k = 0; k < 2; k++) begin
                m_res[k] = m_acc[k];
                m_acc[k] = hit ? 1 : 0;
            end
            m_done = 1;
            m_frame = (m_frame + 1) % 65536;
        end else if (hit) begin
            for (int k = 0; k < 2; k++) begin
                if (m_acc[k] == maxv[k]) m_ovf[k] = 1;
                else m_acc[k]++;
            end
        end
        m_px = px;
        m_py = py;
    endfunction

    function automatic logic [31:0] exp_rd(input int k, input int a);
        case (a)
            0: return 32'((m_ovf[k] << 1) | m_done);
            1: return 32'(m_res[k]);
            2: return 32'(m_frame);
            3: return 32'(m_x0);
            4: return 32'(m_y0);
            5: return 32'(m_w);
            6: return 32'(m_h);
            default: return 32'(m_en);
        endcase
    endfunction

    function automatic logic [31:0] exp_so(input int px, input int py, input int rgb);
`ifdef PROBE_OUTLINE_EN
        bit ix, iy, b;
        ix = px >= m_x0 && px < m_x0 + m_w;
        iy = py >= m_y0 && py < m_y0 + m_h;
        b = m_en != 0 && m_w != 0 && m_h != 0 &&
            (((px == m_x0 || px == m_x0 + m_w - 1) && iy) ||
             ((py == m_y0 || py == m_y0 + m_h - 1) && ix));
        return b ? 32'h0000_0f00 : 32'(rgb);
`else
        return 32'(rgb & 4095);
`endif
    endfunction

    // Called at a negedge; reads all registers inside the low clock phase.
    task automatic check_regs();
        read = 1'b1;
        for (int a = 0; a < 8; a++) begin
            addr = 14'(a);
            #1;
            check_eq($sformatf("rd%0d", a), rd_data, exp_rd(0, a));
            if (a < 3) check_eq($sformatf("cw4_rd%0d", a), rd4, exp_rd(1, a));
        end
        read = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_write(input int a, input int d);
        @(negedge clk);
        cs = 1'b1; write = 1'b1; addr = 14'(a); wr_data = 32'(d);
        model_write(a, d);
        @(negedge clk);
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic pixel(input int px, input int py, input int rgb, input int n);
        @(negedge clk);
        x = 11'(px); y = 11'(py); si_rgb = 12'(rgb);
        model_pixel(px, py, rgb);
        #1;
        check_eq("so_rgb", {20'b0, so_rgb}, exp_so(px, py, rgb));
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic set_window(input int x0, input int y0, input int w,
                              input int h, input int en);
        do_write(1, x0); do_write(2, y0); do_write(3, w); do_write(4, h);
        do_write(0, en);
    endtask

    // mode 0: all white, 1: random, 2: key except five pixels of the window
    task automatic scan(input int nx, input int ny, input int mode, input int cpp);
        int rgb, n;
        for (int py = 0; py < ny; py++) begin
            for (int px = 0; px < nx; px++) begin
                case (mode)
                    0: rgb = 12'hfff;
                    1: rgb = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4095);
                    default: rgb = ((py == 20 && px >= 10 && px <= 13) ||
                                    (py == 21 && px == 10)) ? 12'h123 : 0;
                endcase
                n = (cpp == 0) ? $urandom_range(1, 3) : cpp;
                pixel(px, py, rgb, n);
            end
        end
    endtask

    task automatic frame_end_check();
        pixel(0, 0, 12'hfff, 2);
        tick();
        check_regs();
    endtask

    task automatic reset_now();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        check_regs();
        @(negedge clk);
        reset = 1'b0;
        model_pixel(int'(x), int'(y), int'(si_rgb));
    endtask

    initial begin
        model_reset();
        // 1: reset state and pass-through
        si_rgb = 12'h0a5;
        #2;
        check_eq("so_pass", {20'b0, so_rgb}, 32'h0a5);
        check_regs();
        @(negedge clk);
        reset = 1'b0;

        // 2: 4x3 window, all non-key, 4 clk per pixel
        set_window(10, 20, 4, 3, 1);
        scan(16, 24, 0, 4);
        frame_end_check();
        check_eq("t2_count", rd_data, exp_rd(0, 7));
        addr = 14'd1; #1; check_eq("t2_rd1", rd_data, 32'd12);
        addr = 14'd0; #1; check_eq("t2_rd0", rd_data, 32'd1);
        addr = 14'd2; #1; check_eq("t2_rd2", rd_data, 32'd1);

        // 3: only five non-key pixels, then empty window
        scan(16, 24, 2, 1);
        frame_end_check();
        addr = 14'd1; #1; check_eq("t3_rd1", rd_data, 32'd5);
        do_write(3, 0);
        scan(16, 24, 0, 2);
        frame_end_check();
        addr = 14'd1; #1; check_eq("t3_w0", rd_data, 32'd0);

        // 4: clear coinciding with frame end, then clear alone
        do_write(3, 4);
        scan(16, 24, 1, 1);
        @(negedge clk);
        cs = 1'b1; write = 1'b1; addr = 14'd5; wr_data = 32'd0;
        x = 11'd0; y = 11'd0; si_rgb = 12'h0;
        model_clear();
        model_pixel(0, 0, 0);
        @(negedge clk);
        cs = 1'b0; write = 1'b0;
        check_regs();
        addr = 14'd0; #1; check_eq("t4_latch", rd_data & 32'h1, 32'h1);
        do_write(5, 32'hdead);
        check_regs();
        addr = 14'd0; #1; check_eq("t4_clear", rd_data & 32'h1, 32'h0);

        // frame/range boundaries: HMAX and VMAX clipping
        set_window(636, 0, 10, 5, 1);
        for (int px = 630; px < 650; px++) pixel(px, 2, 12'h7, 1);
        frame_end_check();
        set_window(0, 476, 3, 10, 1);
        for (int py = 470; py < 490; py++) pixel(1, py, 12'h7, 2);
        frame_end_check();
        addr = 14'd1; #1; check_eq("vmax_clip", rd_data, 32'd4);

        // randomized windows and frames
        for (int f = 0; f < 6; f++) begin
            set_window($urandom_range(0, 20), $urandom_range(0, 20),
                       $urandom_range(0, 10), $urandom_range(0, 10),
                       ($urandom_range(0, 9) != 0) ? 1 : 0);
            if ($urandom_range(0, 1) == 1) do_write(5, 0);
            scan(24, 24, 1, 0);
            frame_end_check();
        end

        // 5: saturation in the CW=4 instance, then reset mid-frame
        set_window(2, 2, 5, 5, 1);
        do_write(5, 0);
        scan(10, 10, 0, 1);
        frame_end_check();
        addr = 14'd1; #1; check_eq("t5_sat", rd4, 32'd15);
        addr = 14'd0; #1; check_eq("t5_flags", rd4, 32'd3);
        for (int px = 1; px < 6; px++) pixel(px, 3, 12'hfff, 1);
        reset_now();
        check_regs();

`ifdef PROBE_OUTLINE_EN
        // 6: outline on border pixel only
        set_window(10, 20, 4, 3, 1);
        pixel(10, 21, 12'h0a5, 1);
        check_eq("t6_border", {20'b0, so_rgb}, 32'hf00);
        pixel(11, 21, 12'h0a5, 1);
        check_eq("t6_inner", {20'b0, so_rgb}, 32'h0a5);
        frame_end_check();
        addr = 14'd1; #1; check_eq("t6_rd1", rd_data, 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
